// File: rtl/seq_calculator_if.sv
// Request/response bundle for seq_calculator: operand handshake in, result handshake and flags out.
interface seq_calculator_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry, ovf, busy
   );
endinterface

// File: rtl/seq_calculator.sv
// Sequential calculator: single-cycle ALU ops, iterative shift-add multiply,
// registered result/flags held in DONE until the consumer accepts them.
module seq_calculator #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   seq_calculator_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_carry;
   logic               r_ovf;

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [CW-1:0]      r_cnt;

   logic               w_accept;
   logic               w_mul_last;
   logic [2*WIDTH-1:0] w_prod_next;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [CW-1:0]      w_shamt;
   logic [2*WIDTH-1:0] w_shl;
   logic [WIDTH-1:0]   w_alu_res;
   logic               w_alu_c;
   logic               w_alu_o;

   assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
   assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
   assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (bus.op == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:  if (w_mul_last) w_next = S_DONE;
         S_DONE: if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         S_DONE:  bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.result = r_result;
   assign bus.zero   = r_zero;
   assign bus.carry  = r_carry;
   assign bus.ovf    = r_ovf;

   // ---------------- single-cycle ALU ----------------
   // Shift runs in a 2*WIDTH field so the bits pushed past the MSB feed the carry flag.
   assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
   assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
   assign w_shamt = bus.b[CW-1:0];
   assign w_shl   = {{WIDTH{1'b0}}, bus.a} << w_shamt;

   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_o   = 1'b0;
      case (bus.op)
         3'b000: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_o   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         3'b001: begin
            w_alu_res = w_diff[WIDTH-1:0];
            w_alu_c   = w_diff[WIDTH];
            w_alu_o   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         3'b010: w_alu_res = bus.a | bus.b;
         3'b011: w_alu_res = (bus.a == bus.b) ? '0 : WIDTH'(1);
         3'b100: w_alu_res = bus.a & bus.b;
         3'b101: w_alu_res = bus.a ^ bus.b;
         3'b111: begin
            w_alu_res = w_shl[WIDTH-1:0];
            w_alu_c   = |w_shl[2*WIDTH-1:WIDTH];
         end
         default: ;
      endcase
   end

   // ---------------- shift-add multiplier ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (w_accept && (bus.op == OP_MUL)) begin
         r_mcand  <= {{WIDTH{1'b0}}, bus.a};
         r_mplier <= bus.b;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
         r_prod   <= w_prod_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // ---------------- result and flag registers ----------------
   // The last multiply step bypasses r_prod so the product lands on the MUL->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept && (bus.op != OP_MUL)) begin
         r_result <= w_alu_res;
         r_zero   <= (w_alu_res == '0);
         r_carry  <= w_alu_c;
         r_ovf    <= w_alu_o;
      end else if (w_mul_last) begin
         r_result <= w_prod_next[WIDTH-1:0];
         r_zero   <= (w_prod_next[WIDTH-1:0] == '0);
         r_carry  <= |w_prod_next[2*WIDTH-1:WIDTH];
         r_ovf    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator: per-cycle behavioural model plus directed literal cases.
module tb_seq_calculator;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_calculator_if #(.WIDTH(W)) bus ();

   seq_calculator #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference arithmetic straight from the operation rules, using plain integers.
   function automatic void ref_op(input int op, input int x, input int y,
                                  output int r, output bit z, output bit c, output bit o);
      int mask, half, sx, sy, t, shw;
      mask = (1 << W) - 1;
      half = 1 << (W - 1);
      shw  = 1 << $clog2(W);
      sx   = (x >= half) ? x - (1 << W) : x;
      sy   = (y >= half) ? y - (1 << W) : y;
      r = 0; c = 0; o = 0;
      case (op)
         0: begin t = x + y; r = t & mask; c = (t > mask);
                  o = (sx + sy > half - 1) || (sx + sy < -half); end
         1: begin t = x - y; r = t & mask; c = (x < y);
                  o = (sx - sy > half - 1) || (sx - sy < -half); end
         2: r = x | y;
         3: r = (x == y) ? 0 : 1;
         4: r = x & y;
         5: r = x ^ y;
         6: begin t = x * y; r = t & mask; c = (t > mask); end
         default: begin t = x << (y % shw); r = t & mask; c = (t > mask); end
      endcase
      z = (r == 0);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle model and compare ----------------
   initial begin : compare_proc
      int m_st;            // 0 idle, 1 multiplying, 2 result held
      int m_cnt;
      int m_res, p_res;
      bit m_z, m_c, m_o, p_z, p_c, p_o;
      logic [W+5:0] exp_v, act_v;
      m_st = 0; m_cnt = 0; m_res = 0; m_z = 0; m_c = 0; m_o = 0;
      p_res = 0; p_z = 0; p_c = 0; p_o = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_st = 0; m_res = 0; m_z = 0; m_c = 0; m_o = 0;
         end else begin
            case (m_st)
               0: if (bus.in_valid) begin
                     if (bus.op == 3'b110) begin
                        ref_op(6, int'(bus.a), int'(bus.b), p_res, p_z, p_c, p_o);
                        m_cnt = W;
                        m_st  = 1;
                     end else begin
                        ref_op(int'(bus.op), int'(bus.a), int'(bus.b), m_res, m_z, m_c, m_o);
                        m_st = 2;
                     end
                  end
               1: begin
                     m_cnt--;
                     if (m_cnt == 0) begin
                        m_res = p_res; m_z = p_z; m_c = p_c; m_o = p_o;
                        m_st  = 2;
                     end
                  end
               default: if (bus.out_ready) m_st = 0;
            endcase
         end
         #1;
         exp_v = {(m_st == 0), (m_st == 2), (m_st != 0), W'(m_res), m_z, m_c, m_o};
         act_v = {bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.zero, bus.carry, bus.ovf};
         check("cycle_model", act_v, exp_v);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_idle();
      int g = 0;
      while (!bus.in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!bus.in_ready) check("wait_idle_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, input bit junk, input bit chk,
                         input int er, input bit ez, input bit ec, input bit eo, input int elat);
      int lat;
      logic [W+2:0] snap;
      wait_idle();
      bus.in_valid  = 1'b1;
      bus.a         = x;
      bus.b         = y;
      bus.op        = op;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = junk;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.op       = 3'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (chk) begin
         check("latency", lat, elat);
         check("result", bus.result, er);
         check("flags_zco", {bus.zero, bus.carry, bus.ovf}, {ez, ec, eo});
      end
      snap = {bus.result, bus.zero, bus.carry, bus.ovf};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_stable", {bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.carry, bus.ovf},
               {2'b10, snap});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      if (chk) check("back_to_idle", {bus.in_ready, bus.out_valid}, 2'b10);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return W'(1 << (W - 1));
         3: return W'((1 << (W - 1)) - 1);
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stim
      int r;
      bit z, c, o;

      // Pin the reference model to hand-computed values.
      ref_op(0, 200, 100, r, z, c, o); check("model_add", {r[7:0], z, c, o}, {8'd44, 3'b010});
      ref_op(1, 5, 7, r, z, c, o);     check("model_sub", {r[7:0], z, c, o}, {8'd254, 3'b010});
      ref_op(6, 16, 16, r, z, c, o);   check("model_mul", {r[7:0], z, c, o}, {8'd0, 3'b110});
      ref_op(7, 129, 1, r, z, c, o);   check("model_shl", {r[7:0], z, c, o}, {8'd2, 3'b010});

      // Reset with a request presented: must not be accepted.
      bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.op = 3'b000; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("reset_state", {bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.zero, bus.carry, bus.ovf},
            {3'b100, 8'd0, 3'b000});

      run_op(3'b000, 8'd200, 8'd100, 0, 0, 1, 44,  0, 1, 0, 1);
      run_op(3'b000, 8'd100, 8'd100, 0, 0, 1, 200, 0, 0, 1, 1);
      run_op(3'b001, 8'd5,   8'd7,   0, 0, 1, 254, 0, 1, 0, 1);
      run_op(3'b110, 8'd15,  8'd17,  0, 1, 1, 255, 0, 0, 0, 9);
      run_op(3'b110, 8'd16,  8'd16,  0, 0, 1, 0,   1, 1, 0, 9);
      run_op(3'b011, 8'd9,   8'd9,   0, 0, 1, 0,   1, 0, 0, 1);
      run_op(3'b111, 8'h81,  8'd1,   0, 0, 1, 2,   0, 1, 0, 1);
      run_op(3'b111, 8'h5a,  8'd8,   0, 0, 1, 'h5a, 0, 0, 0, 1);
      run_op(3'b000, 8'd3,   8'd4,   5, 1, 1, 7,   0, 0, 0, 1);

      // Reset in the third multiply cycle discards the operation.
      wait_idle();
      bus.in_valid = 1'b1; bus.a = 8'd15; bus.b = 8'd17; bus.op = 3'b110;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_mul_reset", {bus.in_ready, bus.out_valid, bus.busy, bus.result}, {3'b100, 8'd0});
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_stale_valid", bus.out_valid, 0);
      end
      run_op(3'b000, 8'd1, 8'd2, 0, 0, 1, 3, 0, 0, 0, 1);

      // Randomized traffic, checked by the per-cycle model.
      for (int n = 0; n < 300; n++) begin
         run_op(3'($urandom), pick(), pick(), $urandom_range(0, 3), 1'($urandom), 0, 0, 0, 0, 0, 0);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned (two's complement for overflow flag).
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select, per REQ-012.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result; zero, carry, ovf: output, 1 bit each, registered flags; busy: output, 1 bit, high whenever state is not IDLE.

Function
REQ-012 Op encoding: 000 a+b; 001 a-b; 010 a|b; 011 compare (0 if a==b else 1); 100 a&b; 101 a^b; 110 a*b (low WIDTH bits); 111 a<<b[$clog2(WIDTH)-1:0] (logical, zero fill).
REQ-013 FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1, out_valid=0; accept when in_valid&&in_ready; a, b, op captured at that edge.
REQ-015 Accept of non-multiply op: result/flags registered at the accept edge; next state DONE (out_valid high 1 cycle after accept).
REQ-016 Accept of op 110: next state MUL; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (out_valid high WIDTH+1 cycles after accept).
REQ-017 MUL: in_ready=0, out_valid=0; in_valid ignored; result output holds previous value until DONE entered.
REQ-018 DONE: out_valid=1, in_ready=0; result/flags stable while out_ready=0 (unbounded backpressure).
REQ-019 DONE with out_ready=1: next state IDLE; no same-cycle new accept (minimum 2 cycles per op).
REQ-020 Arithmetic: add/sub computed at WIDTH+1 bits; result = low WIDTH bits (wrap-around).
REQ-021 carry: add = carry-out; sub = borrow (a<b unsigned); mul = 1 if any bit of full 2*WIDTH product above bit WIDTH-1 is set; shift = 1 if any bit shifted out is 1; others 0.
REQ-022 ovf: add/sub = signed two's-complement overflow; all other ops 0.
REQ-023 zero = (result == 0) for every op, including compare and mul.
REQ-024 Flags update only together with result (same edge).
REQ-025 Shift amount >= WIDTH impossible by width truncation; amount 0 returns a, carry 0.

Reset
REQ-026 rst=1 at a rising edge: state IDLE, result=0, zero=0, carry=0, ovf=0, out_valid=0, busy=0, multiplier datapath cleared; in_ready=1 the cycle after rst deasserts.
REQ-027 rst overrides all other inputs, including mid-MUL and in DONE; in-flight operation discarded, no out_valid produced for it.
REQ-028 in_valid during rst not accepted.

Verification (WIDTH=8)
REQ-029 add a=200,b=100 -> next cycle out_valid=1, result=44, carry=1, ovf=0, zero=0.
REQ-030 add a=100,b=100 -> result=200, carry=0, ovf=1; sub a=5,b=7 -> result=254, carry=1, ovf=0.
REQ-031 mul a=15,b=17 -> out_valid exactly 9 cycles after accept, result=255, carry=0; mul a=16,b=16 -> result=0, carry=1, zero=1.
REQ-032 compare a=9,b=9 -> result=0, zero=1; shift a=0x81,b=1 -> result=0x02, carry=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> result/flags/out_valid constant, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst pulsed 1 cycle at MUL cycle 3 -> IDLE, result=0, no out_valid for that op; a subsequent add 1+2 returns 3.
